// File: rtl/reboot_pkg.sv
// Shared types and constants for the target-MCU reboot sequencer.
// Imported by the arbiter and the sequencer top.
package reboot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_PWR_OFF,
        ST_PWR_ON,
        ST_HOLDOFF
    } state_e;

    localparam int CAUSE_TC  = 0;
    localparam int CAUSE_WDT = 1;
    localparam int CAUSE_SW  = 2;
    localparam int CAUSE_UV  = 3;

    localparam int N_SRC_DEF = 4;

    // Telecommand and undervoltage reboots remove power; the others are warm.
    localparam logic [N_SRC_DEF-1:0] PWR_MASK_DEF = 4'b1001;

    localparam int CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/reboot_prio_arb.sv
// Lowest-index-wins one-hot picker; all-zero input gives all-zero output.
// Purely combinational.
module reboot_prio_arb
    import reboot_pkg::*;
#(
    parameter int N = N_SRC_DEF
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    // Two's-complement trick isolates the lowest set bit.
    assign gnt_o = req_i & (~req_i + N'(1));

endmodule

// File: rtl/reboot_sequencer.sv
// Arbitrates reboot requests and sequences reset / power of the target MCU,
// followed by a holdoff window; reports last cause and a saturating count.
module reboot_sequencer
    import reboot_pkg::*;
#(
    parameter int              N_SRC          = N_SRC_DEF,
    parameter int              RST_CYCLES     = 16,
    parameter int              PWR_OFF_CYCLES = 64,
    parameter int              HOLDOFF_CYCLES = 256,
    parameter logic [N_SRC-1:0] PWR_MASK      = N_SRC'(PWR_MASK_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req_i,
    input  logic             cnt_clr_i,
    output logic [N_SRC-1:0] ack_o,
    output logic             target_rst_n_o,
    output logic             target_pwr_en_o,
    output logic             busy_o,
    output logic [N_SRC-1:0] last_cause_o,
    output logic [CNT_W-1:0] reboot_cnt_o
);

    localparam int MAXC = max3(RST_CYCLES, PWR_OFF_CYCLES, HOLDOFF_CYCLES);
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [CW-1:0] LD_RST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LD_POFF = CW'(PWR_OFF_CYCLES - 1);
    localparam logic [CW-1:0] LD_HOLD = CW'(HOLDOFF_CYCLES - 1);
    localparam logic [CW-1:0] TMR_ONE = CW'(1);

    state_e             state_q;
    logic [CW-1:0]      tmr_q;
    logic [N_SRC-1:0]   pend_q;
    logic [N_SRC-1:0]   pend_d;
    logic [N_SRC-1:0]   ack_q;
    logic [N_SRC-1:0]   cause_q;
    logic               rst_n_q;
    logic               pwr_en_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [N_SRC-1:0]   cand;
    logic [N_SRC-1:0]   pick;
    logic [N_SRC-1:0]   grant;
    logic               start;
    logic               tmr_done;

    assign cand = pend_q | req_i;

    reboot_prio_arb #(
        .N(N_SRC)
    ) u_arb (
        .req_i(cand),
        .gnt_o(pick)
    );

    assign start    = (state_q == ST_IDLE) && (|cand);
    assign grant    = start ? pick : '0;
    assign tmr_done = (tmr_q == '0);

    // Anything not granted this cycle stays latched, including re-requests.
    assign pend_d = cand & ~grant;

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = start ? CNT_W'(1) : '0;
        end else if (start && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tmr_q    <= '0;
            pend_q   <= '0;
            ack_q    <= '0;
            cause_q  <= '0;
            rst_n_q  <= 1'b1;
            pwr_en_q <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            ack_q  <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ASSERT;
                        tmr_q   <= LD_RST;
                        ack_q   <= grant;
                        cause_q <= grant;
                        rst_n_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (!tmr_done) begin
                        tmr_q <= tmr_q - TMR_ONE;
                    end else if (|(PWR_MASK & cause_q)) begin
                        state_q  <= ST_PWR_OFF;
                        tmr_q    <= LD_POFF;
                        pwr_en_q <= 1'b0;
                    end else begin
                        state_q <= ST_HOLDOFF;
                        tmr_q   <= LD_HOLD;
                        rst_n_q <= 1'b1;
                    end
                end
                ST_PWR_OFF: begin
                    if (!tmr_done) begin
                        tmr_q <= tmr_q - TMR_ONE;
                    end else begin
                        state_q  <= ST_PWR_ON;
                        tmr_q    <= LD_RST;
                        pwr_en_q <= 1'b1;
                    end
                end
                ST_PWR_ON: begin
                    if (!tmr_done) begin
                        tmr_q <= tmr_q - TMR_ONE;
                    end else begin
                        state_q <= ST_HOLDOFF;
                        tmr_q   <= LD_HOLD;
                        rst_n_q <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (!tmr_done) begin
                        tmr_q <= tmr_q - TMR_ONE;
                    end else begin
                        state_q <= ST_IDLE;
                        tmr_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o           = ack_q;
    assign target_rst_n_o  = rst_n_q;
    assign target_pwr_en_o = pwr_en_q;
    assign busy_o          = busy_q;
    assign last_cause_o    = cause_q;
    assign reboot_cnt_o    = cnt_q;

endmodule

// File: tb/tb_reboot_sequencer.sv
// Directed bench for reboot_sequencer: default timing instance plus a
// short-timing instance used for count saturation and clear.
module tb_reboot_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       clr = 1'b0;
    logic [3:0] ack;
    logic       rst_n;
    logic       pwr_en;
    logic       busy;
    logic [3:0] cause;
    logic [7:0] cnt;

    logic [3:0] req2 = '0;
    logic       clr2 = 1'b0;
    logic [3:0] ack2;
    logic       rst_n2;
    logic       pwr_en2;
    logic       busy2;
    logic [3:0] cause2;
    logic [7:0] cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reboot_sequencer dut (
        .clk(clk),
        .rst(rst),
        .req_i(req),
        .cnt_clr_i(clr),
        .ack_o(ack),
        .target_rst_n_o(rst_n),
        .target_pwr_en_o(pwr_en),
        .busy_o(busy),
        .last_cause_o(cause),
        .reboot_cnt_o(cnt)
    );

    reboot_sequencer #(
        .RST_CYCLES(1),
        .PWR_OFF_CYCLES(1),
        .HOLDOFF_CYCLES(1)
    ) dut2 (
        .clk(clk),
        .rst(rst),
        .req_i(req2),
        .cnt_clr_i(clr2),
        .ack_o(ack2),
        .target_rst_n_o(rst_n2),
        .target_pwr_en_o(pwr_en2),
        .busy_o(busy2),
        .last_cause_o(cause2),
        .reboot_cnt_o(cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int i;
        i = 0;
        while (busy && i < bound) begin
            tick();
            i++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    // Drives src in cycle 0, optional extra pulse inj in cycle inj_c, and
    // checks every cycle up to the first idle cycle after holdoff.
    task automatic run_seq(input string tag, input logic [3:0] src,
                           input logic [3:0] exp_ack, input logic pwr,
                           input int inj_c, input logic [3:0] inj);
        int last;
        int rl;
        int be;
        last = pwr ? 353 : 273;
        rl   = pwr ? 96 : 16;
        be   = pwr ? 352 : 272;
        req  = src;
        tick();
        for (int c = 1; c <= last; c++) begin
            req = (c == inj_c) ? inj : 4'b0000;
            chk($sformatf("%s ack c%0d", tag, c), 32'(ack),
                32'((c == 1) ? exp_ack : 4'b0000));
            chk($sformatf("%s rst_n c%0d", tag, c), 32'(rst_n),
                32'(c > rl));
            chk($sformatf("%s pwr c%0d", tag, c), 32'(pwr_en),
                32'(!(pwr && c >= 17 && c <= 80)));
            chk($sformatf("%s busy c%0d", tag, c), 32'(busy),
                32'(c <= be));
            if (c < last) tick();
        end
        chk({tag, " cause"}, 32'(cause), 32'(exp_ack));
    endtask

    initial begin
        int acks;
        do_reset();
        rst = 1'b1;
        chk("rst ack", 32'(ack), 32'd0);
        chk("rst rst_n", 32'(rst_n), 32'd1);
        chk("rst pwr", 32'(pwr_en), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst cause", 32'(cause), 32'd0);
        chk("rst cnt", 32'(cnt), 32'd0);
        chk("rst cnt2", 32'(cnt2), 32'd0);
        rst = 1'b0;
        tick();

        // Warm reboot, software source
        run_seq("warm", 4'b0100, 4'b0100, 1'b0, 0, 4'b0000);
        chk("warm cnt", 32'(cnt), 32'd1);
        tick();
        chk("warm idle", 32'(busy), 32'd0);

        // Power cycle, undervoltage source
        do_reset();
        run_seq("pwr", 4'b1000, 4'b1000, 1'b1, 0, 4'b0000);
        chk("pwr cnt", 32'(cnt), 32'd1);
        tick();
        chk("pwr idle", 32'(busy), 32'd0);

        // Simultaneous: watchdog first, software pending
        do_reset();
        run_seq("sim", 4'b0110, 4'b0010, 1'b0, 0, 4'b0000);
        tick();
        chk("sim ack2", 32'(ack), 32'b0100);
        chk("sim rst_n2", 32'(rst_n), 32'd0);
        chk("sim cause2", 32'(cause), 32'b0100);
        chk("sim cnt", 32'(cnt), 32'd2);
        wait_idle("sim idle", 400);

        // Telecommand arriving mid-sequence
        do_reset();
        run_seq("mid", 4'b0100, 4'b0100, 1'b0, 50, 4'b0001);
        tick();
        chk("mid ack2", 32'(ack), 32'b0001);
        chk("mid cause2", 32'(cause), 32'b0001);
        chk("mid cnt", 32'(cnt), 32'd2);
        wait_idle("mid idle", 400);

        // Reset during power cycle drops outputs and pending requests
        do_reset();
        req = 4'b1000;
        tick();
        for (int c = 1; c <= 40; c++) begin
            req = (c == 20) ? 4'b0001 : 4'b0000;
            rst = (c == 40);
            if (c == 25) chk("rmid pwr_off", 32'(pwr_en), 32'd0);
            tick();
        end
        rst = 1'b0;
        chk("rmid pwr", 32'(pwr_en), 32'd1);
        chk("rmid rst_n", 32'(rst_n), 32'd1);
        chk("rmid busy", 32'(busy), 32'd0);
        chk("rmid cnt", 32'(cnt), 32'd0);
        chk("rmid cause", 32'(cause), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rmid nopend %0d", i), 32'(busy), 32'd0);
        end
        run_seq("rwarm", 4'b0100, 4'b0100, 1'b0, 0, 4'b0000);
        chk("rwarm cnt", 32'(cnt), 32'd1);

        // Saturation and clear on the short-timing instance
        acks = 0;
        req2 = 4'b0100;
        for (int i = 0; i < 3000 && acks < 300; i++) begin
            tick();
            if (ack2 != 4'b0000) acks++;
        end
        chk("sat acks", 32'(acks), 32'd300);
        chk("sat cnt", 32'(cnt2), 32'd255);
        req2 = 4'b0000;
        for (int i = 0; i < 10; i++) tick();
        chk("sat hold", 32'(cnt2), 32'd255);
        chk("sat idle", 32'(busy2), 32'd0);
        req2 = 4'b0100;
        clr2 = 1'b1;
        tick();
        req2 = 4'b0000;
        clr2 = 1'b0;
        chk("clr grant ack", 32'(ack2), 32'b0100);
        chk("clr grant cnt", 32'(cnt2), 32'd1);
        for (int i = 0; i < 6; i++) tick();
        chk("clr idle", 32'(busy2), 32'd0);
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        chk("clr alone cnt", 32'(cnt2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
